// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the MIPS EX stage.
// Results are computed at the start edge into shadow registers and committed after a fixed busy window.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    input  logic [2:0]  mdOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_op_e        op;
    logic [CW-1:0] counter;
    logic [31:0]   shadow_hi;
    logic [31:0]   shadow_lo;
    logic          div_zero;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic          signed_div;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   b_safe;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   quot;
    logic [31:0]   rem;

    assign op     = md_op_e'(mdOp);
    assign prod_s = 64'($signed(inA)) * 64'($signed(inB));
    assign prod_u = {32'd0, inA} * {32'd0, inB};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    // NOTE: every signal driven in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        signed_div = (op == OP_DIV);
        a_neg      = signed_div & inA[31];
        b_neg      = signed_div & inB[31];
        a_mag      = a_neg ? -inA : inA;
        b_mag      = b_neg ? -inB : inB;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem        = a_neg ? -r_mag : r_mag;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            counter   <= '0;
            busy      <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            shadow_hi <= 32'd0;
            shadow_lo <= 32'd0;
            div_zero  <= 1'b0;
        end else if (counter != '0) begin
            counter <= counter - CW'(1);
            if (counter == CW'(1)) begin
                busy <= 1'b0;
                if (!div_zero) begin
                    hi <= shadow_hi;
                    lo <= shadow_lo;
                end
            end
        end else if (start) begin
            unique case (op)
                OP_MULT: begin
                    {shadow_hi, shadow_lo} <= prod_s;
                    div_zero <= 1'b0;
                    counter  <= CW'(MULT_CYCLES);
                    busy     <= 1'b1;
                end
                OP_MULTU: begin
                    {shadow_hi, shadow_lo} <= prod_u;
                    div_zero <= 1'b0;
                    counter  <= CW'(MULT_CYCLES);
                    busy     <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    shadow_hi <= rem;
                    shadow_lo <= quot;
                    div_zero  <= (inB == 32'd0);
                    counter   <= CW'(DIV_CYCLES);
                    busy      <= 1'b1;
                end
                OP_MTHI: hi <= inA;
                OP_MTLO: lo <= inA;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: hand-computed products, quotients and busy-window corner cases.
module tb_mult_div_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] inA;
    logic [31:0] inB;
    logic [2:0]  mdOp;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    mult_div_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .inA  (inA),
        .inB  (inB),
        .mdOp (mdOp),
        .start(start),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge; the rising edge in between is the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdOp  = op;
        inA   = a;
        inB   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mdOp  = OP_NONE;
        inA   = 32'hDEAD_BEEF;
        inB   = 32'h0BAD_F00D;
    endtask

    task automatic wait_done(input string tag, input int n);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check(tag, 32'(cnt), 32'(n));
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        mdOp  = OP_NONE;
        inA   = 32'd0;
        inB   = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        check("mult_busy_t", {31'd0, busy}, 32'd1);
        check("mult_hi_early", hi, 32'd0);
        wait_done("mult_cycles", MULT_CYCLES);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu_cycles", MULT_CYCLES);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_early", lo, 32'hFFFF_FFFE);
        wait_done("div_cycles", DIV_CYCLES);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_negb_cycles", DIV_CYCLES);
        check("div_negb_lo", lo, 32'hFFFF_FFFD);
        check("div_negb_hi", hi, 32'h0000_0001);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf_cycles", DIV_CYCLES);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
        wait_done("divu_cycles", DIV_CYCLES);
        check("divu_lo", lo, 32'h0FFF_FFFF);
        check("divu_hi", hi, 32'h0000_000F);

        issue(OP_MTHI, 32'h1111_1111, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h1111_1111);
        check("mthi_lo", lo, 32'h0FFF_FFFF);
        issue(OP_MTLO, 32'h2222_2222, 32'd0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check("mtlo_lo", lo, 32'h2222_2222);
        check("mtlo_hi", hi, 32'h1111_1111);

        issue(OP_DIVU, 32'd7, 32'd0);
        wait_done("div0_cycles", DIV_CYCLES);
        check("div0_hi", hi, 32'h1111_1111);
        check("div0_lo", lo, 32'h2222_2222);

        issue(OP_MULT, 32'd3, 32'd4);
        issue(OP_MTLO, 32'd5, 32'd0);
        check("mtlo_in_busy_lo", lo, 32'h2222_2222);
        wait_done("mult_after_ign_cycles", MULT_CYCLES - 1);
        check("mult_after_ign_hi", hi, 32'd0);
        check("mult_after_ign_lo", lo, 32'h0000_000C);

        issue(OP_MULT, 32'd5, 32'd6);
        repeat (MULT_CYCLES - 1) @(negedge clk);
        check("tn_busy_before", {31'd0, busy}, 32'd1);
        issue(OP_MTLO, 32'h77, 32'd0);
        check("tn_busy", {31'd0, busy}, 32'd0);
        check("tn_lo", lo, 32'h0000_001E);
        check("tn_hi", hi, 32'd0);
        issue(OP_MTHI, 32'h99, 32'd0);
        check("tn1_hi", hi, 32'h0000_0099);
        check("tn1_lo", lo, 32'h0000_001E);

        issue(OP_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (DIV_CYCLES + 5) @(negedge clk);
        check("rst_after_busy", {31'd0, busy}, 32'd0);
        check("rst_after_hi", hi, 32'd0);
        check("rst_after_lo", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
